// File: rtl/multicycle_controller_pkg.sv
// Shared state, opcode/funct and control encodings for the multicycle controller.
// Optional feature: define MULTICYCLE_JAL_EN to add the JAL state.
package multicycle_controller_pkg;

  localparam int unsigned OP_W     = 6;
  localparam int unsigned FUNCT_W  = 6;
  localparam int unsigned ALUCTL_W = 5;
  localparam int unsigned SRCB_W   = 2;
  localparam int unsigned PCSRC_W  = 2;
  localparam int unsigned STATE_W  = 4;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEXEC = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11,
`ifdef MULTICYCLE_JAL_EN
    S_JR       = 4'd12,
    S_JAL      = 4'd13
`else
    S_JR       = 4'd12
`endif
  } state_e;

  // Opcodes (instr[31:26])
  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;
  localparam logic [OP_W-1:0] OP_JAL   = 6'b000011;

  // R-type funct codes (instr[5:0])
  localparam logic [FUNCT_W-1:0] FN_ADD = 6'b100000;
  localparam logic [FUNCT_W-1:0] FN_SUB = 6'b100010;
  localparam logic [FUNCT_W-1:0] FN_AND = 6'b100100;
  localparam logic [FUNCT_W-1:0] FN_OR  = 6'b100101;
  localparam logic [FUNCT_W-1:0] FN_SLT = 6'b101010;
  localparam logic [FUNCT_W-1:0] FN_JR  = 6'b001000;

  localparam logic [ALUCTL_W-1:0] ALU_ADD = 5'b00000;
  localparam logic [ALUCTL_W-1:0] ALU_SUB = 5'b00001;
  localparam logic [ALUCTL_W-1:0] ALU_AND = 5'b00010;
  localparam logic [ALUCTL_W-1:0] ALU_OR  = 5'b00011;
  localparam logic [ALUCTL_W-1:0] ALU_SLT = 5'b00100;

  localparam logic [SRCB_W-1:0] SRCB_RDB    = 2'b00;
  localparam logic [SRCB_W-1:0] SRCB_FOUR   = 2'b01;
  localparam logic [SRCB_W-1:0] SRCB_IMM    = 2'b10;
  localparam logic [SRCB_W-1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [PCSRC_W-1:0] PCSRC_ALU    = 2'b00;
  localparam logic [PCSRC_W-1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [PCSRC_W-1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [PCSRC_W-1:0] PCSRC_RD1    = 2'b11;

  // Final state of a legal instruction; the retire counter advances on leaving it.
  function automatic logic is_last_state(input state_e s);
    logic last;
    last = 1'b0;
    case (s)
      S_MEMWB, S_MEMWRITE, S_ALUWB, S_BRANCH,
      S_ADDIWB, S_JUMP, S_JR: last = 1'b1;
`ifdef MULTICYCLE_JAL_EN
      S_JAL:                  last = 1'b1;
`endif
      default:                last = 1'b0;
    endcase
    return last;
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// R-type funct to ALUControl decode with a valid flag for the supported functs.
// Unaffected by MULTICYCLE_JAL_EN.
module alu_decoder
  import multicycle_controller_pkg::*;
(
  input  logic [FUNCT_W-1:0]  i_funct,
  output logic [ALUCTL_W-1:0] o_alu_control_c,
  output logic                o_funct_valid_c
);

  always_comb begin
    o_alu_control_c = ALU_ADD;
    o_funct_valid_c = 1'b1;
    case (i_funct)
      FN_ADD:  o_alu_control_c = ALU_ADD;
      FN_SUB:  o_alu_control_c = ALU_SUB;
      FN_AND:  o_alu_control_c = ALU_AND;
      FN_OR:   o_alu_control_c = ALU_OR;
      FN_SLT:  o_alu_control_c = ALU_SLT;
      default: o_funct_valid_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore control FSM for a multicycle MIPS-subset datapath, with retire counter and sticky illegal flag.
// Define MULTICYCLE_JAL_EN to decode opcode 000011 as jal; otherwise it is illegal and link stays 0.
module multicycle_controller
  import multicycle_controller_pkg::*;
#(
  parameter int unsigned RETIRE_W = 16
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [OP_W-1:0]     opcode,
  input  logic [FUNCT_W-1:0]  funct,
  input  logic                zero,
  output logic                PCWrite,
  output logic                IorD,
  output logic                IRWrite,
  output logic                memWrite,
  output logic                regWriteEnable,
  output logic                regDst,
  output logic                memToReg,
  output logic                ALUSrcA,
  output logic [SRCB_W-1:0]   ALUSrcB,
  output logic [PCSRC_W-1:0]  PCSrc,
  output logic                link,
  output logic [ALUCTL_W-1:0] ALUControl,
  output logic                illegal,
  output logic [RETIRE_W-1:0] retired
);

  state_e                r_state;
  state_e                w_next_state;
  logic                  r_illegal;
  logic [RETIRE_W-1:0]   r_retired;

  logic                  w_pc_write;
  logic                  w_iord;
  logic                  w_ir_write;
  logic                  w_mem_write;
  logic                  w_reg_write;
  logic                  w_reg_dst;
  logic                  w_mem_to_reg;
  logic                  w_alu_src_a;
  logic [SRCB_W-1:0]     w_alu_src_b;
  logic [PCSRC_W-1:0]    w_pc_src;
  logic [ALUCTL_W-1:0]   w_alu_control;
  logic                  w_set_illegal;
  logic                  w_retire;
  logic [ALUCTL_W-1:0]   w_funct_alu_ctl;
  logic                  w_funct_valid;
`ifdef MULTICYCLE_JAL_EN
  logic                  w_link;
`endif

  alu_decoder u_alu_decoder (
    .i_funct         (funct),
    .o_alu_control_c (w_funct_alu_ctl),
    .o_funct_valid_c (w_funct_valid)
  );

  assign w_retire = is_last_state(r_state);

  // State, retire counter and sticky illegal flag; reset aborts any in-flight instruction.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state   <= S_FETCH;
      r_retired <= '0;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_retire) begin
        r_retired <= r_retired + RETIRE_W'(1);
      end
      if (w_set_illegal) begin
        r_illegal <= 1'b1;
      end
    end
  end

  // Next-state and Moore output decode.
  always_comb begin
    w_next_state  = r_state;
    w_pc_write    = 1'b0;
    w_iord        = 1'b0;
    w_ir_write    = 1'b0;
    w_mem_write   = 1'b0;
    w_reg_write   = 1'b0;
    w_reg_dst     = 1'b0;
    w_mem_to_reg  = 1'b0;
    w_alu_src_a   = 1'b0;
    w_alu_src_b   = SRCB_RDB;
    w_pc_src      = PCSRC_ALU;
    w_alu_control = ALU_ADD;
    w_set_illegal = 1'b0;
`ifdef MULTICYCLE_JAL_EN
    w_link        = 1'b0;
`endif

    case (r_state)
      S_FETCH: begin
        w_ir_write   = 1'b1;
        w_alu_src_b  = SRCB_FOUR;
        w_pc_write   = 1'b1;
        w_next_state = S_DECODE;
      end

      S_DECODE: begin
        // Branch target is computed speculatively while decoding.
        w_alu_src_b = SRCB_IMM_SH;
        case (opcode)
          OP_LW, OP_SW: w_next_state = S_MEMADR;
          OP_RTYPE:     w_next_state = (funct == FN_JR) ? S_JR : S_EXECUTE;
          OP_BEQ:       w_next_state = S_BRANCH;
          OP_ADDI:      w_next_state = S_ADDIEXEC;
          OP_J:         w_next_state = S_JUMP;
`ifdef MULTICYCLE_JAL_EN
          OP_JAL:       w_next_state = S_JAL;
`endif
          default: begin
            w_next_state  = S_FETCH;
            w_set_illegal = 1'b1;
          end
        endcase
      end

      S_MEMADR: begin
        w_alu_src_a  = 1'b1;
        w_alu_src_b  = SRCB_IMM;
        w_next_state = (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end

      S_MEMREAD: begin
        w_iord       = 1'b1;
        w_next_state = S_MEMWB;
      end

      S_MEMWB: begin
        w_mem_to_reg = 1'b1;
        w_reg_write  = 1'b1;
        w_next_state = S_FETCH;
      end

      S_MEMWRITE: begin
        w_iord       = 1'b1;
        w_mem_write  = 1'b1;
        w_next_state = S_FETCH;
      end

      S_EXECUTE: begin
        w_alu_src_a   = 1'b1;
        w_alu_control = w_funct_alu_ctl;
        if (w_funct_valid) begin
          w_next_state = S_ALUWB;
        end else begin
          w_next_state  = S_FETCH;
          w_set_illegal = 1'b1;
        end
      end

      S_ALUWB: begin
        w_reg_dst    = 1'b1;
        w_reg_write  = 1'b1;
        w_next_state = S_FETCH;
      end

      S_BRANCH: begin
        w_alu_src_a   = 1'b1;
        w_alu_control = ALU_SUB;
        w_pc_src      = PCSRC_ALUOUT;
        w_pc_write    = zero;
        w_next_state  = S_FETCH;
      end

      S_ADDIEXEC: begin
        w_alu_src_a  = 1'b1;
        w_alu_src_b  = SRCB_IMM;
        w_next_state = S_ADDIWB;
      end

      S_ADDIWB: begin
        w_reg_write  = 1'b1;
        w_next_state = S_FETCH;
      end

      S_JUMP: begin
        w_pc_src     = PCSRC_JUMP;
        w_pc_write   = 1'b1;
        w_next_state = S_FETCH;
      end

      S_JR: begin
        w_pc_src     = PCSRC_RD1;
        w_pc_write   = 1'b1;
        w_next_state = S_FETCH;
      end

`ifdef MULTICYCLE_JAL_EN
      S_JAL: begin
        w_pc_src     = PCSRC_JUMP;
        w_pc_write   = 1'b1;
        w_link       = 1'b1;
        w_reg_write  = 1'b1;
        w_next_state = S_FETCH;
      end
`endif

      default: w_next_state = S_FETCH;
    endcase
  end

  // Architectural write enables are held off for the whole time reset is asserted.
  assign PCWrite        = w_pc_write  & reset_n;
  assign IRWrite        = w_ir_write  & reset_n;
  assign memWrite       = w_mem_write & reset_n;
  assign regWriteEnable = w_reg_write & reset_n;

  assign IorD       = w_iord;
  assign regDst     = w_reg_dst;
  assign memToReg   = w_mem_to_reg;
  assign ALUSrcA    = w_alu_src_a;
  assign ALUSrcB    = w_alu_src_b;
  assign PCSrc      = w_pc_src;
  assign ALUControl = w_alu_control;
  assign illegal    = r_illegal;
  assign retired    = r_retired;

`ifdef MULTICYCLE_JAL_EN
  assign link = w_link;
`else
  assign link = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: per-cycle expected controls queued per instruction.
// Expectations follow MULTICYCLE_JAL_EN when it is defined for the build.
module tb_multicycle_controller;

  localparam int unsigned RW = 4;

  localparam int T_FETCH    = 0;
  localparam int T_DECODE   = 1;
  localparam int T_MEMADR   = 2;
  localparam int T_MEMREAD  = 3;
  localparam int T_MEMWB    = 4;
  localparam int T_MEMWRITE = 5;
  localparam int T_EXECUTE  = 6;
  localparam int T_ALUWB    = 7;
  localparam int T_BRANCH   = 8;
  localparam int T_ADDIEXEC = 9;
  localparam int T_ADDIWB   = 10;
  localparam int T_JUMP     = 11;
  localparam int T_JR       = 12;
  localparam int T_JAL      = 13;

  logic          clock;
  logic          reset_n;
  logic [5:0]    opcode;
  logic [5:0]    funct;
  logic          zero;
  logic          PCWrite, IorD, IRWrite, memWrite, regWriteEnable;
  logic          regDst, memToReg, ALUSrcA, link, illegal;
  logic [1:0]    ALUSrcB, PCSrc;
  logic [4:0]    ALUControl;
  logic [RW-1:0] retired;
  logic [17:0]   obs_ctl;

  typedef struct {
    string         tag;
    logic [17:0]   ctl;
    logic          illegal;
    logic [RW-1:0] retired;
  } exp_t;

  exp_t          sb_q[$];
  int            n_checks;
  int            n_errors;
  logic          m_illegal;
  logic [RW-1:0] m_retired;

  multicycle_controller #(.RETIRE_W(RW)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .opcode         (opcode),
    .funct          (funct),
    .zero           (zero),
    .PCWrite        (PCWrite),
    .IorD           (IorD),
    .IRWrite        (IRWrite),
    .memWrite       (memWrite),
    .regWriteEnable (regWriteEnable),
    .regDst         (regDst),
    .memToReg       (memToReg),
    .ALUSrcA        (ALUSrcA),
    .ALUSrcB        (ALUSrcB),
    .PCSrc          (PCSrc),
    .link           (link),
    .ALUControl     (ALUControl),
    .illegal        (illegal),
    .retired        (retired)
  );

  assign obs_ctl = {PCWrite, IorD, IRWrite, memWrite, regWriteEnable, regDst, memToReg,
                    ALUSrcA, ALUSrcB, PCSrc, link, ALUControl};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [17:0] ctl(input logic pcw, input logic iord, input logic irw,
                                      input logic memw, input logic rwe, input logic rdst,
                                      input logic m2r, input logic srca, input logic [1:0] srcb,
                                      input logic [1:0] pcsrc, input logic lnk,
                                      input logic [4:0] aluc);
    return {pcw, iord, irw, memw, rwe, rdst, m2r, srca, srcb, pcsrc, lnk, aluc};
  endfunction

  function automatic logic [17:0] exp_ctl(input int st, input logic z, input logic [4:0] aluc);
    case (st)
      T_FETCH:    return ctl(1, 0, 1, 0, 0, 0, 0, 0, 2'b01, 2'b00, 0, 5'b00000);
      T_DECODE:   return ctl(0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 0, 5'b00000);
      T_MEMADR:   return ctl(0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 0, 5'b00000);
      T_MEMREAD:  return ctl(0, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 5'b00000);
      T_MEMWB:    return ctl(0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 0, 5'b00000);
      T_MEMWRITE: return ctl(0, 1, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0, 5'b00000);
      T_EXECUTE:  return ctl(0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 0, aluc);
      T_ALUWB:    return ctl(0, 0, 0, 0, 1, 1, 0, 0, 2'b00, 2'b00, 0, 5'b00000);
      T_BRANCH:   return ctl(z, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 0, 5'b00001);
      T_ADDIEXEC: return ctl(0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 0, 5'b00000);
      T_ADDIWB:   return ctl(0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 0, 5'b00000);
      T_JUMP:     return ctl(1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 0, 5'b00000);
      T_JR:       return ctl(1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b11, 0, 5'b00000);
      default:    return ctl(1, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b10, 1, 5'b00000);
    endcase
  endfunction

  // Reset forces PCWrite, IRWrite, memWrite and regWriteEnable low.
  function automatic logic [17:0] gate(input logic [17:0] v);
    logic [17:0] r;
    r     = v;
    r[17] = 1'b0;
    r[15] = 1'b0;
    r[14] = 1'b0;
    r[13] = 1'b0;
    return r;
  endfunction

  always @(negedge clock) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_eq({e.tag, ".ctl"},     32'(obs_ctl), 32'(e.ctl));
      check_eq({e.tag, ".illegal"}, 32'(illegal), 32'(e.illegal));
      check_eq({e.tag, ".retired"}, 32'(retired), 32'(e.retired));
    end
  end

  // Called just after a rising edge with the DUT in FETCH.
  task automatic do_reset();
    exp_t e;
    reset_n   = 1'b0;
    e.tag     = "reset";
    e.ctl     = gate(exp_ctl(T_FETCH, 1'b0, 5'b00000));
    e.illegal = m_illegal;
    e.retired = m_retired;
    sb_q.push_back(e);
    @(posedge clock);
    #1;
    reset_n   = 1'b1;
    m_illegal = 1'b0;
    m_retired = '0;
  endtask

  // rst_at >= 0 pulls reset low during that cycle index of the instruction.
  task automatic run_instr(input string name, input logic [5:0] op, input logic [5:0] fn,
                           input logic z, input int rst_at);
    int         seq[$];
    logic [4:0] aluc;
    logic       legal;
    exp_t       e;
    aluc  = 5'b00000;
    legal = 1'b1;
    seq.push_back(T_FETCH);
    seq.push_back(T_DECODE);
    case (op)
      6'b100011: begin seq.push_back(T_MEMADR); seq.push_back(T_MEMREAD); seq.push_back(T_MEMWB); end
      6'b101011: begin seq.push_back(T_MEMADR); seq.push_back(T_MEMWRITE); end
      6'b000100: seq.push_back(T_BRANCH);
      6'b001000: begin seq.push_back(T_ADDIEXEC); seq.push_back(T_ADDIWB); end
      6'b000010: seq.push_back(T_JUMP);
`ifdef MULTICYCLE_JAL_EN
      6'b000011: seq.push_back(T_JAL);
`endif
      6'b000000: begin
        if (fn == 6'b001000) begin
          seq.push_back(T_JR);
        end else begin
          seq.push_back(T_EXECUTE);
          case (fn)
            6'b100000: aluc = 5'b00000;
            6'b100010: aluc = 5'b00001;
            6'b100100: aluc = 5'b00010;
            6'b100101: aluc = 5'b00011;
            6'b101010: aluc = 5'b00100;
            default:   legal = 1'b0;
          endcase
          if (legal) seq.push_back(T_ALUWB);
        end
      end
      default: legal = 1'b0;
    endcase
    for (int i = 0; i < seq.size(); i++) begin
      if (rst_at < 0 || i <= rst_at) begin
        e.tag     = $sformatf("%s.c%0d", name, i + 1);
        e.ctl     = exp_ctl(seq[i], z, aluc);
        if (i == rst_at) e.ctl = gate(e.ctl);
        e.illegal = m_illegal;
        e.retired = m_retired;
        sb_q.push_back(e);
      end
    end
    opcode = op;
    funct  = fn;
    zero   = z;
    if (rst_at >= 0) begin
      repeat (rst_at) @(posedge clock);
      #1;
      reset_n = 1'b0;
      @(posedge clock);
      #1;
      reset_n   = 1'b1;
      m_illegal = 1'b0;
      m_retired = '0;
    end else begin
      repeat (seq.size()) @(posedge clock);
      #1;
      if (legal) m_retired = m_retired + RW'(1);
      else       m_illegal = 1'b1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, %0d entries pending", sb_q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    m_illegal = 1'b0;
    m_retired = '0;
    reset_n   = 1'b0;
    opcode    = 6'b000000;
    funct     = 6'b000000;
    zero      = 1'b0;
    @(posedge clock);
    #1;
    do_reset();

    run_instr("lw",     6'b100011, 6'b000000, 1'b0, -1);
    run_instr("beq_t",  6'b000100, 6'b000000, 1'b1, -1);
    run_instr("beq_nt", 6'b000100, 6'b000000, 1'b0, -1);
    run_instr("sw",     6'b101011, 6'b000000, 1'b0, -1);
    run_instr("addi",   6'b001000, 6'b000000, 1'b0, -1);
    run_instr("j",      6'b000010, 6'b000000, 1'b0, -1);
    run_instr("jr",     6'b000000, 6'b001000, 1'b0, -1);
    run_instr("add",    6'b000000, 6'b100000, 1'b0, -1);
    run_instr("sub",    6'b000000, 6'b100010, 1'b0, -1);
    run_instr("and",    6'b000000, 6'b100100, 1'b0, -1);
    run_instr("or",     6'b000000, 6'b100101, 1'b0, -1);
    run_instr("jal",    6'b000011, 6'b000000, 1'b0, -1);

    do_reset();
    run_instr("slt",       6'b000000, 6'b101010, 1'b0, -1);
    run_instr("bad_funct", 6'b000000, 6'b000111, 1'b0, -1);
    run_instr("after_bad", 6'b001000, 6'b000000, 1'b0, -1);

    do_reset();
    run_instr("bad_op",  6'b111111, 6'b000000, 1'b0, -1);
    run_instr("beq2",    6'b000100, 6'b000000, 1'b1, -1);
    run_instr("sw_rst",  6'b101011, 6'b000000, 1'b0, 3);
    run_instr("lw_rst",  6'b100011, 6'b000000, 1'b0, 4);
    run_instr("beq_rst", 6'b000100, 6'b000000, 1'b1, 2);
    run_instr("addi2",   6'b001000, 6'b000000, 1'b0, -1);

    do_reset();
    for (int k = 0; k < (1 << RW) + 1; k++) begin
      run_instr($sformatf("jwrap%0d", k), 6'b000010, 6'b000000, 1'b0, -1);
    end
    check_eq("wrap_retired", 32'(retired), 32'd1);

    @(negedge clock);
    check_eq("sb_drain", 32'(sb_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have parameter RETIRE_W, default 16, giving the width of the retired-instruction counter.
REQ-002 SHALL have port clock, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 SHALL have port reset_n, input, 1 bit: reset, synchronous, active-low.
REQ-004 SHALL have port opcode, input, 6 bits: instr[31:26] from the instruction register.
REQ-005 SHALL have port funct, input, 6 bits: instr[5:0].
REQ-006 SHALL have port zero, input, 1 bit: ALU result equals zero.
REQ-007 SHALL have port PCWrite, output, 1 bit: PC register enable, with the branch condition already folded in.
REQ-008 SHALL have port IorD, output, 1 bit: memory address select, 0 = pcQ, 1 = ALUOut.
REQ-009 SHALL have port IRWrite, output, 1 bit: instruction register enable.
REQ-010 SHALL have port memWrite, output, 1 bit: memory write enable.
REQ-011 SHALL have port regWriteEnable, output, 1 bit: register-file write enable.
REQ-012 SHALL have port regDst, output, 1 bit: write-address select, 1 = rd, 0 = rt.
REQ-013 SHALL have port memToReg, output, 1 bit: write-data select, 1 = memory data, 0 = ALUOut.
REQ-014 SHALL have port ALUSrcA, output, 1 bit: 0 = pcQ, 1 = RDA.
REQ-015 SHALL have port ALUSrcB, output, 2 bits: 00 = RDB, 01 = 4, 10 = SignImm, 11 = SignImm<<2.
REQ-016 SHALL have port PCSrc, output, 2 bits: 00 = ALUResult, 01 = ALUOut, 10 = jump target, 11 = RD1.
REQ-017 SHALL have port link, output, 1 bit: forces A3 = 31 and WD3 = pcQ.
REQ-018 SHALL have port ALUControl, output, 5 bits: ADD = 00000, SUB = 00001, AND = 00010, OR = 00011, SLT = 00100.
REQ-019 SHALL have port illegal, output, 1 bit: sticky flag for an undecodable instruction.
REQ-020 SHALL have port retired, output, RETIRE_W bits: count of completed legal instructions.

Function
REQ-021 SHALL be a Moore FSM; all outputs decode from state only, except PCWrite in BRANCH, which equals zero. Unlisted outputs are 0 and ALUControl defaults to ADD.
REQ-022 FETCH SHALL drive IorD=0, IRWrite=1, ALUSrcA=0, ALUSrcB=01, ADD, PCSrc=00, PCWrite=1, and go to DECODE.
REQ-023 DECODE SHALL drive ALUSrcA=0, ALUSrcB=11, ADD, then dispatch as follows:
- 100011 and 101011 go to MEMADR.
- 000000 goes to EXECUTE, or to JR if funct=001000.
- 000100 goes to BRANCH.
- 001000 goes to ADDIEXEC.
- 000010 goes to JUMP.
- 000011 goes to JAL.
REQ-024 MEMADR SHALL drive ALUSrcA=1, ALUSrcB=10, ADD; it goes to MEMREAD for lw and to MEMWRITE for sw.
REQ-025 MEMREAD SHALL drive IorD=1 and go to MEMWB; MEMWB SHALL drive regDst=0, memToReg=1, regWriteEnable=1 and go to FETCH.
REQ-026 MEMWRITE SHALL drive IorD=1, memWrite=1 and go to FETCH.
REQ-027 EXECUTE SHALL drive ALUSrcA=1, ALUSrcB=00, with ALUControl decoded from funct:
- 100000 = ADD
- 100010 = SUB
- 100100 = AND
- 100101 = OR
- 101010 = SLT
It then goes to ALUWB.
REQ-028 ALUWB SHALL drive regDst=1, memToReg=0, regWriteEnable=1 and go to FETCH.
REQ-029 BRANCH SHALL drive ALUSrcA=1, ALUSrcB=00, SUB, PCSrc=01, PCWrite=zero, and go to FETCH.
REQ-030 ADDIEXEC SHALL drive ALUSrcA=1, ALUSrcB=10, ADD and go to ADDIWB; ADDIWB SHALL drive regDst=0, memToReg=0, regWriteEnable=1 and go to FETCH.
REQ-031 JUMP SHALL drive PCSrc=10, PCWrite=1; JR SHALL drive PCSrc=11, PCWrite=1; both go to FETCH.
REQ-032 Handling of an undecodable opcode, or of an R-type funct outside REQ-027 and jr:
- Undecodable opcode: DECODE goes to FETCH and sets illegal=1.
- Undecodable R-type funct: EXECUTE goes to FETCH and sets illegal=1.
- No register or memory write occurs.
- retired is unchanged.
REQ-033 retired SHALL increment by 1 on the last state of every legal instruction and wrap from all-ones to 0.
- Last states are MEMWB, MEMWRITE, ALUWB, BRANCH, ADDIWB, JUMP, JR and JAL.
- A not-taken branch still counts.
REQ-034 Instruction latency SHALL be:
- 3 cycles for j, jr, jal and beq.
- 4 cycles for sw, R-type and addi.
- 5 cycles for lw.

Reset
REQ-035 reset_n low at a rising edge SHALL set the state to FETCH, retired to 0 and illegal to 0, aborting any in-flight instruction.
REQ-036 While reset_n is low, PCWrite, IRWrite, memWrite and regWriteEnable SHALL be forced to 0.

Configuration
REQ-037 With MULTICYCLE_JAL_EN defined, opcode 000011 SHALL dispatch to JAL, which drives PCSrc=10, PCWrite=1, link=1, regWriteEnable=1 and then goes to FETCH.
REQ-038 Without MULTICYCLE_JAL_EN, the JAL state SHALL not exist, opcode 000011 SHALL be treated as illegal, and link SHALL be tied to 0.

Structure
REQ-039 A shared package SHALL hold the state enum, the opcode and funct constants, and the ALUControl, ALUSrcB and PCSrc encodings.
REQ-040 A single sub-module, alu_decoder, SHALL map funct to ALUControl and to a funct-valid flag.

Verification
REQ-041 Scenario: lw (opcode 100011) after reset.
- Response: states FETCH, DECODE, MEMADR, MEMREAD, MEMWB over 5 cycles.
- Response: regWriteEnable=1 and memToReg=1 only in cycle 5.
- Response: retired=1.
REQ-042 Scenario: beq with zero=1, then beq with zero=0.
- Response: in BRANCH, PCWrite is 1 and then 0 respectively, with PCSrc=01.
- Response: retired=2.
REQ-043 Scenario: R-type with funct=101010, then funct=000111.
- Response: ALUControl=00100 in EXECUTE for the first instruction.
- Response: for the second, illegal=1, no regWriteEnable pulse, and retired unchanged.
REQ-044 Scenario: reset_n low during MEMWRITE.
- Response: memWrite=0 in that cycle.
- Response: next state FETCH, with retired=0 and illegal=0.
REQ-045 Scenario: 2^RETIRE_W + 1 jumps.
- Response: retired wraps to 1.
REQ-046 Scenario: opcode 000011, with and without MULTICYCLE_JAL_EN.
- Response with the macro: a link=1, PCWrite=1 cycle.
- Response without the macro: illegal=1.
